// File: rtl/rsqrt_pkg.sv
// rsqrt_pkg: shared widths, fixed-point format and saturation limits for the rsqrt evaluator
package rsqrt_pkg;
  localparam int DW = 16;
  localparam int Q_FRAC = 8;
  localparam int RND = 128;
  localparam logic [DW-1:0] Y_MAX = 16'h7FFF;
  localparam logic [DW-1:0] Y_MIN = 16'h0000;
endpackage

// File: rtl/rsqrt_pwl_eval_if.sv
// rsqrt_pwl_eval_if: sample/LUT inputs and result outputs of the evaluator; master drives, slave is the evaluator
interface rsqrt_pwl_eval_if #(parameter int DW = 16);
  logic in_valid;
  logic [DW-1:0] x_in;
  logic lut_valid;
  logic [DW-1:0] slope_in;
  logic [DW-1:0] intercept_in;
  logic out_valid;
  logic [DW-1:0] y_out;
  logic sat_flag;
  logic align_err;
  modport master(output in_valid, x_in, lut_valid, slope_in, intercept_in,
                 input out_valid, y_out, sat_flag, align_err);
  modport slave(input in_valid, x_in, lut_valid, slope_in, intercept_in,
                output out_valid, y_out, sat_flag, align_err);
endinterface

// File: rtl/rsqrt_pwl_eval_fifo.sv
// x_align_fifo: sync FIFO delaying x to meet its LUT coefficients; ports push/din, pop/dout/pop_ok, err on overflow/underflow
module x_align_fifo #(
  parameter int DW = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          pop_ok,
  output logic          err
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic empty, full, byp, wr, rd;
  always_comb begin
    empty = cnt == '0;
    full = cnt == (AW+1)'(DEPTH);
    // push+pop on an empty FIFO hands x_in straight through without touching storage
    byp = empty && push && pop;
    dout = byp ? din : mem[rp];
    pop_ok = pop && (!empty || push);
    wr = push && (!full || pop) && !byp;
    rd = pop_ok && !byp;
    err = (push && full && !pop) || (pop && empty && !push);
  end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/rsqrt_pwl_eval.sv
// rsqrt_pwl_eval: y = slope*x + intercept in Q8.8 with round half-up and clamp to 0..0x7FFF; ports clk, rst, bus (slave)
module rsqrt_pwl_eval
  import rsqrt_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  rsqrt_pwl_eval_if.slave bus
);
  logic [DW-1:0] x;
  logic pop_ok, err, e1_valid, sat_lo, sat_hi;
  logic signed [2*DW:0] prod;
  logic signed [DW-1:0] icpt;
  logic signed [2*DW+1:0] sum, r;
  logic [DW-1:0] y_n;
  x_align_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(bus.in_valid), .din(bus.x_in),
    .pop(bus.lut_valid), .dout(x), .pop_ok(pop_ok), .err(err)
  );
  always_comb begin
    sum = (2*DW+2)'(prod) + ((2*DW+2)'(icpt) <<< Q_FRAC);
    r = (sum + (2*DW+2)'(RND)) >>> Q_FRAC;
    sat_lo = r[2*DW+1];
    sat_hi = !r[2*DW+1] && |r[2*DW:DW-1];
    y_n = sat_lo ? Y_MIN : sat_hi ? Y_MAX : r[DW-1:0];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      e1_valid <= 1'b0;
      prod <= '0;
      icpt <= '0;
      bus.out_valid <= 1'b0;
      bus.y_out <= '0;
      bus.sat_flag <= 1'b0;
      bus.align_err <= 1'b0;
    end else begin
      e1_valid <= pop_ok;
      if (pop_ok) begin
        prod <= $signed(bus.slope_in) * $signed({1'b0, x});
        icpt <= $signed(bus.intercept_in);
      end
      bus.out_valid <= e1_valid;
      if (e1_valid) begin
        bus.y_out <= y_n;
        bus.sat_flag <= sat_lo || sat_hi;
      end
      bus.align_err <= bus.align_err || err;
    end
endmodule

// File: doc/rsqrt_pwl_eval.md
Name: rsqrt_pwl_eval

Overview:
- Evaluation stage directly downstream of the rsqrt slope/intercept LUT.
- Aligns each input sample x with its LUT segment coefficients, then computes y = slope*x + intercept with rounding and saturation.
- Emits a Q8.8 reciprocal-square-root result for the normalization datapath.
- Internal x-alignment FIFO absorbs the LUT's fixed 2-cycle latency and flags any misalignment.

Parameters:
- DW, 16, data width of x, slope, intercept and result (Q8.8).
- FIFO_DEPTH, 4, x-alignment FIFO entries (power of 2, >= 4).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample strobe; the same strobe drives the LUT's in_valid.
- x_in  in  DW  unsigned Q8.8 input; the same value drives the LUT's x_in.
- lut_valid  in  1  LUT out_valid.
- slope_in  in  DW  signed Q8.8 slope from the LUT.
- intercept_in  in  DW  signed Q8.8 intercept from the LUT.
- out_valid  out  1  result strobe.
- y_out  out  DW  signed Q8.8 result, range 0x0000..0x7FFF.
- sat_flag  out  1  qualified by out_valid: this result was clamped.
- align_err  out  1  sticky: FIFO overflow or underflow occurred; cleared only by rst.

Behaviour:
- Reset: all outputs 0, FIFO empty, pipeline valids 0. Reset mid-operation discards every in-flight sample; no out_valid follows reset until a new in_valid.
- FIFO push/pop:
  - Push x_in when in_valid = 1; pop the head when lut_valid = 1.
  - Simultaneous push and pop: count unchanged. This is legal even when full or empty.
    - Empty: the popped value is the head, which is the pushed x_in bypassed in the same cycle.
    - Full: both operations proceed.
  - Push when full without a pop: sample dropped, align_err <= 1.
  - Pop when empty without a push: align_err <= 1, and that LUT result is discarded (no out_valid for it).
  - Read/write pointers wrap modulo FIFO_DEPTH. Count register is log2(FIFO_DEPTH)+1 bits.
- Stage E1 (register on a valid pop):
  - prod = signed(slope_in) * signed({1'b0, x}), 33-bit, Q16.16.
  - Register the intercept alongside prod.
  - e1_valid <= valid pop.
- Stage E2:
  - sum = prod + (sign-extended intercept << 8), 34-bit.
  - Round half-up: r = (sum + 128) >>> 8.
  - If r < 0: y = 0x0000, sat = 1.
  - Else if r > 0x7FFF: y = 0x7FFF, sat = 1.
  - Else: y = r[15:0], sat = 0.
  - Register into y_out, sat_flag, and out_valid <= e1_valid.
- Latency:
  - out_valid rises 2 cycles after lut_valid.
  - In a normal chain with the LUT: 4 cycles after in_valid.
  - Throughput: 1 sample/cycle. No backpressure.
- y_out and sat_flag hold their last values while out_valid = 0.

Decomposition:
- Shared package rsqrt_pkg:
  - DW, Q_FRAC = 8.
  - Saturation limits Y_MAX = 16'h7FFF and Y_MIN = 16'h0000.
  - Rounding constant RND = 128.
- One sub-module: x_align_fifo (sync FIFO with count, full/empty, same-cycle push/pop bypass). Evaluation pipeline stays in the top.

Test Plan:
- LUT chained, x_in = 0x0100 (slope 0xFE80, intercept 0x027C) -> out_valid 4 cycles after in_valid, y_out = 0x00FC, sat_flag = 0.
- LUT chained, back-to-back x = 0x0010, 0x0400 on consecutive cycles -> y_out = 0x0CB8 then 0x003E on consecutive cycles, order preserved.
- LUT chained, x = 0x1000 (slope 0xFFFB, intercept 0x0047) -> sum negative, y_out = 0x0000, sat_flag = 1.
- Direct drive: push x = 0xFFFF; lut_valid with slope 0x7FFF, intercept 0x7FFF -> y_out = 0x7FFF, sat_flag = 1.
- Direct drive: lut_valid with FIFO empty -> align_err = 1 and stays set, no out_valid. Then 5 pushes without pops -> 5th dropped, align_err remains 1.
- Assert rst while 3 samples are in flight -> outputs 0 asynchronously, FIFO empty, no out_valid after release. A fresh x = 0x0100 then yields 0x00FC.
